// File: rtl/debounce_pkg.sv
// Shared types and default timing values for the pushbutton debouncer.
// Latency: none (types and constants only).
// Backpressure: none.
package debounce_pkg;

  // Per-channel debounce state. REPEATING is only reached in builds
  // with auto-repeat enabled.
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } btn_state_t;

  // Consecutive identical strobe samples needed to change level (7.5 ms at 2.5 ms/strobe).
  localparam int STABLE_SAMPLES_DEF = 3;
  // Strobes held before the first auto-repeat pulse (500 ms).
  localparam int REPEAT_DELAY_DEF   = 200;
  // Strobes between later auto-repeat pulses (100 ms).
  localparam int REPEAT_RATE_DEF    = 40;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-FF synchroniser, strobe-sampled shift reg, state machine,
// optional auto-repeat (BTN_DEBOUNCE_REPEAT_EN). Latency: level/pulses 1 cycle after
// the completing strobe. Backpressure: none; pulses are fire-and-forget.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
`ifdef BTN_DEBOUNCE_REPEAT_EN
  , parameter int REPEAT_DELAY = REPEAT_DELAY_DEF
  , parameter int REPEAT_RATE  = REPEAT_RATE_DEF
`endif
) (
  input  logic Clk_100M,
  input  logic rst_n,
  input  logic slow_clk_en,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  logic [1:0]                sync_q;
  logic [STABLE_SAMPLES-1:0] shreg_q;
  logic                      all_ones;
  logic                      all_zeros;
  btn_state_t                state_q;

  assign all_ones  = &shreg_q;
  assign all_zeros = ~|shreg_q;

  // Bring the asynchronous button onto Clk_100M.
  always_ff @(posedge Clk_100M or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_raw};
  end

  // Shift in one synchronised sample per strobe; idle between strobes.
  always_ff @(posedge Clk_100M or negedge rst_n) begin
    if (!rst_n)           shreg_q <= '0;
    else if (slow_clk_en) shreg_q <= {shreg_q[STABLE_SAMPLES-2:0], sync_q[1]};
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
  logic [CNT_W-1:0] rep_cnt_q;
  logic             repeat_q;

  // Level/press/release/repeat state machine with saturating strobe counter.
  always_ff @(posedge Clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RELEASED;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      repeat_q    <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      repeat_q    <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (all_ones) begin
            state_q   <= PRESSED;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
            rep_cnt_q <= '0;
          end
        end
        default: begin
          if (all_zeros) begin
            state_q     <= RELEASED;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
            rep_cnt_q   <= '0;
          end else if ((state_q == PRESSED && rep_cnt_q == CNT_W'(REPEAT_DELAY)) ||
                       (state_q == REPEATING && rep_cnt_q == CNT_W'(REPEAT_RATE))) begin
            // Restart the interval; a strobe landing this same cycle still counts.
            state_q   <= REPEATING;
            repeat_q  <= 1'b1;
            rep_cnt_q <= {{(CNT_W-1){1'b0}}, slow_clk_en};
          end else if (slow_clk_en && rep_cnt_q != {CNT_W{1'b1}}) begin
            rep_cnt_q <= rep_cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign btn_repeat = repeat_q;
`else
  // Level/press/release state machine (no auto-repeat in this build).
  always_ff @(posedge Clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RELEASED;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (all_ones) begin
            state_q   <= PRESSED;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end
        end
        default: begin
          if (all_zeros) begin
            state_q     <= RELEASED;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end
        end
      endcase
    end
  end

  assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// N_BTN independent debouncers sharing one slow strobe; auto-repeat via BTN_DEBOUNCE_REPEAT_EN.
// Latency: 2-cycle sync + STABLE_SAMPLES strobes, outputs 1 cycle after completing strobe.
// Backpressure: none; pulses are single-cycle and not held.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
`ifdef BTN_DEBOUNCE_REPEAT_EN
  , parameter int REPEAT_DELAY = REPEAT_DELAY_DEF
  , parameter int REPEAT_RATE  = REPEAT_RATE_DEF
`endif
) (
  input  logic             Clk_100M,
  input  logic             rst_n,
  input  logic             slow_clk_en,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  // Reset asserts immediately but releases synchronously to Clk_100M.
  always_ff @(posedge Clk_100M or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_sync_n = rst_sync_q[1];

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES)
`ifdef BTN_DEBOUNCE_REPEAT_EN
      , .REPEAT_DELAY (REPEAT_DELAY)
      , .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_ch (
      .Clk_100M    (Clk_100M),
      .rst_n       (rst_sync_n),
      .slow_clk_en (slow_clk_en),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: strobe every 10 cycles, hand-computed expectations.
// Latency: n/a. Backpressure: n/a.
// Auto-repeat expectations apply when BTN_DEBOUNCE_REPEAT_EN is defined.
module tb_button_debouncer;

  logic       Clk_100M = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk_en = 1'b0;
  logic [3:0] btn_raw = 4'hF;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

  always #5 Clk_100M = ~Clk_100M;

  button_debouncer #(
    .N_BTN          (4),
    .STABLE_SAMPLES (3)
`ifdef BTN_DEBOUNCE_REPEAT_EN
    , .REPEAT_DELAY (8)
    , .REPEAT_RATE  (4)
`endif
  ) dut (
    .Clk_100M    (Clk_100M),
    .rst_n       (rst_n),
    .slow_clk_en (slow_clk_en),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_num = 0;
  int strobe_cyc = 0;
  int rst_nz = 0;
  int excl_err = 0;
  int press_cnt[4], press_strobe[4], press_lat[4], press_cyc[4];
  int rel_cnt[4], rel_strobe[4], rel_lat[4];
  int rep_cnt[4], rep_first[4], rep_last[4], rep_lat[4];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    strobe_num = 0;
    rst_nz = 0;
    for (int c = 0; c < 4; c++) begin
      press_cnt[c] = 0; press_strobe[c] = -1; press_lat[c] = -1; press_cyc[c] = -1;
      rel_cnt[c] = 0;   rel_strobe[c] = -1;   rel_lat[c] = -1;
      rep_cnt[c] = 0;   rep_first[c] = -1;    rep_last[c] = -1; rep_lat[c] = -1;
    end
  endtask

  // One clock: drive strobe, sample 1 ns after the edge, log any pulses.
  task automatic step(input logic en);
    slow_clk_en = en;
    @(posedge Clk_100M);
    #1;
    cyc++;
    if (en) begin
      strobe_num++;
      strobe_cyc = cyc;
    end
    if (!rst_n && (btn_level | btn_press | btn_release | btn_repeat) != 4'h0) rst_nz++;
    for (int c = 0; c < 4; c++) begin
      if (int'(btn_press[c]) + int'(btn_release[c]) + int'(btn_repeat[c]) > 1) excl_err++;
      if (btn_press[c]) begin
        press_cnt[c]++; press_strobe[c] = strobe_num;
        press_lat[c] = cyc - strobe_cyc; press_cyc[c] = cyc;
      end
      if (btn_release[c]) begin
        rel_cnt[c]++; rel_strobe[c] = strobe_num; rel_lat[c] = cyc - strobe_cyc;
      end
      if (btn_repeat[c]) begin
        rep_cnt[c]++;
        if (rep_first[c] < 0) rep_first[c] = strobe_num;
        rep_last[c] = strobe_num; rep_lat[c] = cyc - strobe_cyc;
      end
    end
  endtask

  // n strobe periods (9 idle cycles then the strobe), then two trailing cycles.
  task automatic run(input int n);
    for (int p = 0; p < n; p++) begin
      repeat (9) step(1'b0);
      step(1'b1);
    end
    repeat (2) step(1'b0);
  endtask

  initial begin
    clear_counts();

    // Reset held with all buttons pressed: every output stays low.
    run(3);
    check_eq("rst_outputs_zero", rst_nz, 0);
    btn_raw = 4'h0;
    rst_n = 1'b1;
    run(2);
    check_eq("post_rst_level", int'(btn_level), 0);

    // Press channel 0 for 6 strobes.
    clear_counts();
    btn_raw[0] = 1'b1;
    run(6);
    check_eq("press0_count", press_cnt[0], 1);
    check_eq("press0_strobe", press_strobe[0], 3);
    check_eq("press0_latency", press_lat[0], 1);
    check_eq("level0_high", int'(btn_level[0]), 1);
    check_eq("press_other_ch", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // Release channel 0.
    clear_counts();
    btn_raw[0] = 1'b0;
    run(4);
    check_eq("rel0_count", rel_cnt[0], 1);
    check_eq("rel0_strobe", rel_strobe[0], 3);
    check_eq("rel0_latency", rel_lat[0], 1);
    check_eq("level0_low", int'(btn_level[0]), 0);
    check_eq("rel0_no_press", press_cnt[0], 0);

    // Bouncing channel 1: alternating samples never settle.
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      btn_raw[1] = (k % 2 == 0);
      run(1);
    end
    btn_raw[1] = 1'b0;
    check_eq("bounce1_press", press_cnt[1], 0);
    check_eq("bounce1_release", rel_cnt[1], 0);
    check_eq("bounce1_level", int'(btn_level[1]), 0);
    run(3);

    // Reset while channel 2 is pressed, button still held afterwards.
    clear_counts();
    btn_raw[2] = 1'b1;
    run(4);
    check_eq("level2_before_rst", int'(btn_level[2]), 1);
    clear_counts();
    rst_n = 1'b0;
    step(1'b0);
    check_eq("level2_in_rst", int'(btn_level[2]), 0);
    run(2);
    check_eq("rel2_in_rst", rel_cnt[2], 0);
    check_eq("rst2_outputs_zero", rst_nz, 0);
    clear_counts();
    rst_n = 1'b1;
    run(4);
    check_eq("press2_after_rst", press_cnt[2], 1);
    check_eq("press2_strobe", press_strobe[2], 3);
    check_eq("rel2_after_rst", rel_cnt[2], 0);
    clear_counts();
    btn_raw[2] = 1'b0;
    run(4);
    check_eq("rel2_count", rel_cnt[2], 1);

    // Long hold on channel 3.
    clear_counts();
    btn_raw[3] = 1'b1;
    run(20);
    check_eq("press3_strobe", press_strobe[3], 3);
`ifdef BTN_DEBOUNCE_REPEAT_EN
    check_eq("rep3_count", rep_cnt[3], 3);
    check_eq("rep3_first", rep_first[3], 11);
    check_eq("rep3_last", rep_last[3], 19);
    check_eq("rep3_latency", rep_lat[3], 1);
`else
    check_eq("rep_disabled", rep_cnt[0] + rep_cnt[1] + rep_cnt[2] + rep_cnt[3], 0);
`endif
    clear_counts();
    btn_raw[3] = 1'b0;
    run(4);
    check_eq("rel3_count", rel_cnt[3], 1);
    check_eq("rel3_no_repeat", rep_cnt[3], 0);

    // Simultaneous press on channels 0 and 1.
    clear_counts();
    btn_raw = 4'b0011;
    run(4);
    check_eq("sim_press0", press_cnt[0], 1);
    check_eq("sim_press1", press_cnt[1], 1);
    check_eq("sim_same_cycle", press_cyc[1], press_cyc[0]);
    check_eq("sim_level", int'(btn_level), 3);

    check_eq("pulse_exclusive", excl_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
